chain_register_word: RTL

Parametrised multi-bit stage of the serial configuration chain. It shifts WIDTH bits through an internal shift register and drives a shadow output word that changes only on a qualified update strobe. It adds a readback capture path and partial-load detection. Instances are concatenated chain_out -> chain_in between the serial controller and the analog/PLL configuration bits.

---
 rtl/chain_register_word_if.sv | 30 +++
 rtl/chain_register_word.sv | 85 ++++++++
 2 files changed

// File: rtl/chain_register_word_if.sv
// Bundles the chain-stage bus: serial in/out, control strobes, readback word and status.
// Latency: none, wiring only.
// Backpressure: none; the serial controller owns the chain timing.
interface chain_register_word_if #(
    parameter int WIDTH = 8
);
    logic             chain_in;
    logic             enable;
    logic             capture;
    logic [WIDTH-1:0] readback_in;
    logic             update;
    logic             clear_error;
    logic             chain_out;
    logic [WIDTH-1:0] bits_out;
    logic             update_ack;
    logic             frame_error;
    logic             loaded;

    // Controller side: drives the strobes and the serial input, observes the stage.
    modport master (
        output chain_in, enable, capture, readback_in, update, clear_error,
        input  chain_out, bits_out, update_ack, frame_error, loaded
    );

    // Stage side.
    modport slave (
        input  chain_in, enable, capture, readback_in, update, clear_error,
        output chain_out, bits_out, update_ack, frame_error, loaded
    );
endinterface

// File: rtl/chain_register_word.sv
// One WIDTH-bit stage of the serial config chain with a shadow word, readback capture and partial-load detection.
// Latency: WIDTH enabled cycles chain_in -> chain_out; bits_out/update_ack one cycle after update.
// Backpressure: none; a partial-load update is rejected and flagged in sticky frame_error.
// Optional CHAIN_NEGEDGE_OUT_EN: re-times chain_out on the falling clock edge for extra hold margin.
module chain_register_word #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    chain_register_word_if.slave cr
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] bits_q;
    logic             ack_q;
    logic             err_q;
    logic             full;

    assign full = (count == FULL);

    // Shift register, bit counter and shadow word. Update always looks at the
    // pre-edge sr/count, so it composes with a same-cycle shift or capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr     <= '0;
            count  <= '0;
            bits_q <= RESET_VALUE;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ack_q <= cr.update && full;

            if (cr.update && full) begin
                bits_q <= sr;
            end

            if (cr.capture) begin
                sr    <= cr.readback_in;
                count <= '0;
            end else if (cr.enable) begin
                sr <= {sr[WIDTH-2:0], cr.chain_in};
                if (cr.update) begin
                    count <= CNT_W'(1);
                end else if (!full) begin
                    count <= count + CNT_W'(1);
                end
            end else if (cr.update) begin
                count <= '0;
            end

            // A rejected update outranks a simultaneous clear.
            if (cr.update && !full) begin
                err_q <= 1'b1;
            end else if (cr.clear_error) begin
                err_q <= 1'b0;
            end
        end
    end

    assign cr.bits_out    = bits_q;
    assign cr.update_ack  = ack_q;
    assign cr.frame_error = err_q;
    assign cr.loaded      = full;

`ifdef CHAIN_NEGEDGE_OUT_EN
    logic chain_out_q;

    // Half-cycle re-time of the MSB; the next stage still sees the same bit at its rising edge.
    always_ff @(negedge clk) begin
        if (reset) begin
            chain_out_q <= 1'b0;
        end else begin
            chain_out_q <= sr[WIDTH-1];
        end
    end

    assign cr.chain_out = chain_out_q;
`else
    assign cr.chain_out = sr[WIDTH-1];
`endif
endmodule
